br_lite_local_arbiter: RTL and testbench
========================================

Name: br_lite_local_arbiter

Overview:
- Shares the BrLite router LOCAL input port among N_REQ on-tile requesters, for example the kernel, a monitor and a DMA.
- Arbitrates round-robin between requesters.
- Stamps each accepted flit with this tile's source address and a rolling id.
- Sequences the router's 4-phase req/ack handshake and gates injection on the router's local_busy flag.
- Sits between the PE-side producers and router port BR_LOCAL (flit_i/req_i/ack_o[BR_LOCAL], local_busy_o).

Parameters:
- ADDRESS, 16'h0000: tile address written into the source field of every injected flit.
- N_REQ, 4: number of requesters, at least 2.
- TIMEOUT, 1024: cycles allowed in REQ without an ack before aborting. 0 disables the timeout.

Ports:
- clk_i, input, 1: clock.
- rst_i, input, 1: reset.
- rq_flit_i, input, br_data_t [N_REQ]: requester flits. The source and id fields are ignored.
- rq_valid_i, input, N_REQ: request pending. Must stay high, with a stable flit, until that requester's done_o.
- rq_done_o, output, N_REQ: one-cycle pulse when the flit is consumed or aborted.
- rq_err_o, output, N_REQ: pulses together with rq_done_o on a timeout abort.
- br_flit_o, output, br_data_t: to router flit_i[BR_LOCAL].
- br_req_o, output, 1: to router req_i[BR_LOCAL].
- br_ack_i, input, 1: from router ack_o[BR_LOCAL].
- br_busy_i, input, 1: from router local_busy_o.
- grant_o, output, $clog2(N_REQ): index of the current or last grant.
- err_sticky_o, output, 1: set on any timeout, cleared only by reset.

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values: state IDLE; br_req_o=0; br_flit_o='0; rq_done_o=0; rq_err_o=0; grant_o=N_REQ-1 (so the first grant goes to index 0); id counter 0; timeout counter 0; err_sticky_o=0.
- Round-robin: the search starts at grant_o+1 and wraps modulo N_REQ. The first requester found with rq_valid_i set wins.
- br_flit_o is registered and held constant from capture until the return to IDLE.

FSM:
- IDLE:
  - If rq_valid_i != 0: register grant_o, capture br_flit_o = rq_flit_i[grant] with source=ADDRESS and id=id counter, go to WAIT_FREE.
  - Otherwise stay.
- WAIT_FREE:
  - If !br_busy_i && !br_ack_i: go to REQ, clear the timeout counter.
  - Otherwise stay. No timeout runs in this state.
- REQ (br_req_o=1):
  - If br_ack_i: pulse rq_done_o[grant], increment the id counter (wraps at the field width), go to DROP.
  - Else if TIMEOUT!=0 and the counter has reached TIMEOUT-1: pulse rq_done_o[grant] and rq_err_o[grant], set err_sticky_o, go to DROP. The id counter is not incremented.
  - Else increment the timeout counter.
- DROP (br_req_o=0):
  - When br_ack_i==0, go to IDLE.
  - Covers both the router's 1-cycle IN_ACK and its held IN_ACK_LOCAL.

Timing and boundary conditions:
- Best-case latency from rq_valid_i rising to br_req_o: 2 cycles (IDLE, then WAIT_FREE, then REQ).
- br_busy_i rising while in REQ does not drop br_req_o; the router is already consuming the flit.
- A requester deasserting rq_valid_i after grant is a protocol violation. The flit is still injected.
- Only one grant is outstanding at a time. Minimum back-to-back spacing is 4 cycles.
- br_ack_i high in IDLE or WAIT_FREE is ignored except for blocking the WAIT_FREE exit.
- rst_i mid-operation: all outputs return to reset values immediately (asynchronously) and no rq_done_o is issued.

Test Plan:
- Single injection: ADDRESS=16'h0102, N_REQ=4, rq_valid_i=4'b0001, id counter 0, router model acks 3 cycles after req → br_req_o high at cycle 2; br_flit_o.source=16'h0102, id=0; rq_done_o=4'b0001 pulses once; br_req_o low after ack; id counter becomes 1.
- Fairness: rq_valid_i=4'b1011 held, router model always acks → grant order 0,1,3,0,1,3, each with exactly one done pulse.
- Busy gating: br_busy_i=1 for 200 cycles with requester 2 valid → br_req_o stays 0 and FSM stays in WAIT_FREE; br_req_o rises 1 cycle after br_busy_i falls.
- Timeout: TIMEOUT=16, router never acks → br_req_o high for exactly 16 cycles; rq_done_o[g] and rq_err_o[g] pulse together; err_sticky_o=1; id counter unchanged.
- Held local ack: ack held high for 5 cycles after req drops → FSM stays in DROP until ack low; the next grant's br_req_o rises no earlier than 2 cycles later.
- Id wrap and reset: 2^idw+1 injections give ids 0..max then 0. Asserting rst_i during REQ clears br_req_o in the same cycle with no done pulse.

Source files
------------

// File: rtl/br_lite_local_arbiter_if.sv
// BrLite flit type and the signal bundle between the local arbiter, its on-tile
// requesters and router port BR_LOCAL.
package br_lite_local_arbiter_pkg;
  localparam int BR_IDW = 4;

  typedef struct packed {
    logic [15:0]       payload;
    logic [15:0]       target;
    logic [15:0]       source;
    logic [BR_IDW-1:0] id;
    logic [3:0]        service;
  } br_data_t;
endpackage

interface br_lite_local_arbiter_if #(parameter int N_REQ = 4);
  localparam int GW = $clog2(N_REQ);

  br_lite_local_arbiter_pkg::br_data_t [N_REQ-1:0] rq_flit_i;
  logic [N_REQ-1:0]                    rq_valid_i;
  logic [N_REQ-1:0]                    rq_done_o;
  logic [N_REQ-1:0]                    rq_err_o;
  br_lite_local_arbiter_pkg::br_data_t br_flit_o;
  logic                                br_req_o;
  logic                                br_ack_i;
  logic                                br_busy_i;
  logic [GW-1:0]                       grant_o;
  logic                                err_sticky_o;

  modport slave (
    input  rq_flit_i, rq_valid_i, br_ack_i, br_busy_i,
    output rq_done_o, rq_err_o, br_flit_o, br_req_o, grant_o, err_sticky_o
  );

  modport master (
    output rq_flit_i, rq_valid_i, br_ack_i, br_busy_i,
    input  rq_done_o, rq_err_o, br_flit_o, br_req_o, grant_o, err_sticky_o
  );
endinterface

// File: rtl/br_lite_local_arbiter.sv
// Round-robin arbiter sharing the BrLite LOCAL port among N_REQ requesters; it stamps
// source/id on each flit and runs the router's 4-phase req/ack handshake.
module br_lite_local_arbiter
  import br_lite_local_arbiter_pkg::*;
#(
  parameter logic [15:0] ADDRESS = 16'h0000,
  parameter int          N_REQ   = 4,
  parameter int          TIMEOUT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  br_lite_local_arbiter_if.slave bus
);

  localparam int GW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_FREE, REQ, DROP} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  br_data_t          flit_q, flit_d;
  logic [BR_IDW-1:0] idCnt_q, idCnt_d;
  logic [TW-1:0]     toCnt_q, toCnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              sticky_q, sticky_d;

  logic [GW-1:0]     pick;
  logic [GW-1:0]     idx;
  logic              found;

  // Search starts one past the last grant so every pending requester gets a turn.
  always_comb begin
    pick  = grant_q;
    idx   = grant_q;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = GW'((int'(grant_q) + k) % N_REQ);
      if (!found && bus.rq_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= GW'(N_REQ - 1);
      flit_q   <= '0;
      idCnt_q  <= '0;
      toCnt_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      flit_q   <= flit_d;
      idCnt_q  <= idCnt_d;
      toCnt_q  <= toCnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    flit_d   = flit_q;
    idCnt_d  = idCnt_q;
    toCnt_d  = toCnt_q;
    done_d   = '0;
    err_d    = '0;
    sticky_d = sticky_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = pick;
          flit_d        = bus.rq_flit_i[pick];
          flit_d.source = ADDRESS;
          flit_d.id     = idCnt_q;
          state_d       = WAIT_FREE;
        end
      end
      WAIT_FREE: begin
        // A lingering ack from the previous transfer must clear before a new request.
        if (!bus.br_busy_i && !bus.br_ack_i) begin
          toCnt_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.br_ack_i) begin
          done_d[grant_q] = 1'b1;
          idCnt_d         = idCnt_q + BR_IDW'(1);
          state_d         = DROP;
        end else if ((TIMEOUT != 0) && (toCnt_q == T_LAST)) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
          sticky_d        = 1'b1;
          state_d         = DROP;
        end else begin
          toCnt_d = toCnt_q + TW'(1);
        end
      end
      DROP: begin
        if (!bus.br_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.br_req_o     = (state_q == REQ);
  assign bus.br_flit_o    = flit_q;
  assign bus.rq_done_o    = done_q;
  assign bus.rq_err_o     = err_q;
  assign bus.grant_o      = grant_q;
  assign bus.err_sticky_o = sticky_q;

endmodule

// File: tb/tb_br_lite_local_arbiter.sv
// Directed bench for br_lite_local_arbiter with a small router model (delayed/held ack)
// and requesters that drop their valid on done.
module tb_br_lite_local_arbiter;
  import br_lite_local_arbiter_pkg::*;

  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  br_lite_local_arbiter_if #(.N_REQ(N)) bus();

  br_lite_local_arbiter #(.ADDRESS(16'h0102), .N_REQ(N), .TIMEOUT(16)) dut (
    .clk_i(clock),
    .rst_i(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Router model knobs and state
  bit ackEnable = 1'b1;
  int ackDelay  = 3;
  int ackHold   = 0;
  int reqSeen   = 0;
  int holdLeft  = 0;
  bit autoClear = 1'b1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid);
    bus.rq_valid_i = valid;
  endtask

  // Advance to the next falling edge, then let the router and requesters react.
  task automatic stepCycle();
    @(negedge clock);
    if (bus.br_req_o) begin
      reqSeen++;
      if (ackEnable && reqSeen >= ackDelay && !bus.br_ack_i) begin
        bus.br_ack_i = 1'b1;
        holdLeft     = ackHold;
      end
    end else begin
      reqSeen = 0;
      if (bus.br_ack_i) begin
        if (holdLeft > 0) holdLeft--;
        else bus.br_ack_i = 1'b0;
      end
    end
    if (autoClear) bus.rq_valid_i = bus.rq_valid_i & ~bus.rq_done_o;
  endtask

  task automatic injectOne(input string tag, input logic [N-1:0] expDone,
                           input logic [1:0] expGrant, input logic [3:0] expId);
    br_data_t seen = '0;
    bit gotDone = 1'b0;
    for (int i = 0; i < 100 && !gotDone; i++) begin
      stepCycle();
      if (bus.br_req_o) seen = bus.br_flit_o;
      if (bus.rq_done_o != '0) gotDone = 1'b1;
    end
    checkOutput({tag, ".done"}, bus.rq_done_o, expDone);
    checkOutput({tag, ".err"}, bus.rq_err_o, '0);
    checkOutput({tag, ".grant"}, bus.grant_o, expGrant);
    checkOutput({tag, ".id"}, seen.id, expId);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawReq;
    bit sawDone;
    int reqCycles;
    int waitCycles;
    bus.rq_valid_i = '0;
    bus.br_ack_i   = 1'b0;
    bus.br_busy_i  = 1'b0;
    for (int i = 0; i < N; i++)
      bus.rq_flit_i[i] = br_data_t'{payload: 16'(16'hA000 + i), target: 16'h0303,
                                    source: 16'hFFFF, id: 4'hF, service: 4'(i)};

    // Reset values
    stepCycle();
    stepCycle();
    checkOutput("rst.req", bus.br_req_o, 0);
    checkOutput("rst.flit", bus.br_flit_o, 0);
    checkOutput("rst.done", bus.rq_done_o, 0);
    checkOutput("rst.err", bus.rq_err_o, 0);
    checkOutput("rst.grant", bus.grant_o, 3);
    checkOutput("rst.sticky", bus.err_sticky_o, 0);
    reset = 1'b0;

    // Single injection from requester 0
    applyStimulus(4'b0001);
    stepCycle();
    checkOutput("single.req@1", bus.br_req_o, 0);
    checkOutput("single.grant", bus.grant_o, 0);
    stepCycle();
    checkOutput("single.req@2", bus.br_req_o, 1);
    checkOutput("single.source", bus.br_flit_o.source, 16'h0102);
    checkOutput("single.id", bus.br_flit_o.id, 0);
    checkOutput("single.payload", bus.br_flit_o.payload, 16'hA000);
    checkOutput("single.target", bus.br_flit_o.target, 16'h0303);
    for (int i = 0; i < 20 && bus.rq_done_o == '0; i++) stepCycle();
    checkOutput("single.done", bus.rq_done_o, 4'b0001);
    checkOutput("single.reqLow", bus.br_req_o, 0);
    stepCycle();
    checkOutput("single.donePulse", bus.rq_done_o, 0);

    // Fairness with 1011 held; last grant was 0
    autoClear = 1'b0;
    applyStimulus(4'b1011);
    begin
      logic [1:0] order [6] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd3, 2'd0};
      for (int k = 0; k < 6; k++)
        injectOne($sformatf("fair%0d", k), 4'(1 << order[k]), order[k], 4'(k + 1));
    end
    applyStimulus(4'b0000);
    autoClear = 1'b1;
    stepCycle();
    stepCycle();

    // Busy gating on requester 2
    bus.br_busy_i = 1'b1;
    applyStimulus(4'b0100);
    sawReq = 1'b0;
    repeat (200) begin
      stepCycle();
      sawReq |= bus.br_req_o;
    end
    checkOutput("busy.noReq", sawReq, 0);
    checkOutput("busy.grant", bus.grant_o, 2);
    bus.br_busy_i = 1'b0;
    stepCycle();
    checkOutput("busy.reqAfterFall", bus.br_req_o, 1);
    bus.br_busy_i = 1'b1;
    stepCycle();
    checkOutput("busy.holdReq", bus.br_req_o, 1);
    bus.br_busy_i = 1'b0;
    injectOne("busy", 4'b0100, 2'd2, 4'd7);

    // Timeout on requester 1
    checkOutput("to.stickyBefore", bus.err_sticky_o, 0);
    ackEnable = 1'b0;
    applyStimulus(4'b0010);
    reqCycles = 0;
    for (int i = 0; i < 100; i++) begin
      stepCycle();
      if (bus.br_req_o) reqCycles++;
      if (bus.rq_done_o != '0) break;
    end
    checkOutput("to.reqCycles", reqCycles, 16);
    checkOutput("to.done", bus.rq_done_o, 4'b0010);
    checkOutput("to.err", bus.rq_err_o, 4'b0010);
    checkOutput("to.sticky", bus.err_sticky_o, 1);
    checkOutput("to.grant", bus.grant_o, 1);
    ackEnable = 1'b1;
    stepCycle();
    checkOutput("to.errPulse", bus.rq_err_o, 0);

    // Held local ack; id unchanged by the timeout
    ackHold = 5;
    applyStimulus(4'b1000);
    injectOne("hold", 4'b1000, 2'd3, 4'd8);
    ackHold = 0;
    applyStimulus(4'b0001);
    waitCycles = 0;
    for (int i = 0; i < 30 && !bus.br_req_o; i++) begin
      stepCycle();
      waitCycles++;
      if (waitCycles == 4) begin
        checkOutput("hold.reqLow", bus.br_req_o, 0);
        checkOutput("hold.ackHigh", bus.br_ack_i, 1);
      end
    end
    checkOutput("hold.reqDelay", waitCycles, 8);
    injectOne("hold2", 4'b0001, 2'd0, 4'd9);

    // Reset, then id wrap over 17 injections
    reset = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("rst2.sticky", bus.err_sticky_o, 0);
    checkOutput("rst2.grant", bus.grant_o, 3);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      applyStimulus(4'b0010);
      injectOne($sformatf("wrap%0d", k), 4'b0010, 2'd1, 4'(k % 16));
    end

    // Reset asserted while in REQ
    ackEnable = 1'b0;
    applyStimulus(4'b0100);
    for (int i = 0; i < 20 && !bus.br_req_o; i++) stepCycle();
    checkOutput("rstReq.inReq", bus.br_req_o, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rstReq.req", bus.br_req_o, 0);
    checkOutput("rstReq.done", bus.rq_done_o, 0);
    checkOutput("rstReq.grant", bus.grant_o, 3);
    checkOutput("rstReq.flit", bus.br_flit_o, 0);
    sawDone = 1'b0;
    repeat (3) begin
      stepCycle();
      sawDone |= (bus.rq_done_o != '0);
    end
    checkOutput("rstReq.noDone", sawDone, 0);
    applyStimulus(4'b0000);
    reset     = 1'b0;
    ackEnable = 1'b1;
    stepCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
